// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC select codes, fetch FSM states and default widths.
// The PC block decodes the same PCSEL_* codes that fetch_unit drives on pc_sel.
package cpu_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;

   localparam logic [1:0] PCSEL_INC    = 2'b00;
   localparam logic [1:0] PCSEL_BRANCH = 2'b10;
   localparam logic [1:0] PCSEL_LOAD   = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_ir_reg.sv
// Instruction register: holds ir_data/ir_pc/ir_valid between capture and accept or flush.
module fetch_ir_reg
   import cpu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture,
   input  logic              flush,
   input  logic [DATA_W-1:0] data,
   input  logic [ADDR_W-1:0] pc,
   input  logic              ir_ready,
   output logic              ir_valid,
   output logic [DATA_W-1:0] ir_data,
   output logic [ADDR_W-1:0] ir_pc
);

   logic accept;

   assign accept = ir_valid & ir_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir_valid <= 1'b0;
         ir_data  <= '0;
         ir_pc    <= '0;
      end else if (capture) begin
         ir_valid <= 1'b1;
         ir_data  <= data;
         ir_pc    <= pc;
      end else if (flush || accept) begin
         ir_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC-driven memory read into an instruction register.
// Optional macro FETCH_TIMEOUT_EN adds a sticky bus-timeout fault (fetch_fault).
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [ADDR_W-1:0] pc_cur,
   output logic              pc_en,
   output logic [1:0]        pc_sel,
   output logic [ADDR_W-1:0] pc_load,
   output logic [ADDR_W-1:0] pc_branch,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              ir_valid,
   input  logic              ir_ready,
   output logic [DATA_W-1:0] ir_data,
   output logic [ADDR_W-1:0] ir_pc,
   input  logic              redirect_valid,
   input  logic [1:0]        redirect_sel,
   input  logic [ADDR_W-1:0] redirect_target,
   output logic              fetch_fault
);

   fetch_state_t state, state_nxt;
   logic         drop, drop_nxt;
   logic         capture, flush;
   logic         timeout_hit;

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] wait_cnt;

   // Counts unanswered request cycles; the last one before the limit trips the fault.
   assign timeout_hit = (state == FETCH) && !mem_ack &&
                        (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt    <= '0;
         fetch_fault <= 1'b0;
      end else if (timeout_hit) begin
         wait_cnt    <= '0;
         fetch_fault <= 1'b1;
      end else if (state == FETCH && !mem_ack) begin
         wait_cnt <= wait_cnt + 1'b1;
      end else begin
         wait_cnt <= '0;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign fetch_fault = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         drop  <= 1'b0;
      end else begin
         state <= state_nxt;
         drop  <= drop_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      drop_nxt  = drop;
      capture   = 1'b0;
      flush     = 1'b0;
      pc_en     = 1'b0;
      pc_sel    = PCSEL_INC;
      pc_load   = '0;
      pc_branch = '0;
      mem_req   = 1'b0;
      mem_addr  = '0;

      // A redirect always owns the PC port, in every state.
      if (redirect_valid) begin
         pc_en  = 1'b1;
         pc_sel = redirect_sel;
         if (redirect_sel == PCSEL_LOAD)   pc_load   = redirect_target;
         if (redirect_sel == PCSEL_BRANCH) pc_branch = redirect_target;
      end

      case (state)
         IDLE: begin
            if (!redirect_valid && run && !fetch_fault) state_nxt = FETCH;
         end
         FETCH: begin
            mem_req  = 1'b1;
            mem_addr = pc_cur;
            if (mem_ack) begin
               drop_nxt = 1'b0;
               if (!drop && !redirect_valid) begin
                  capture   = 1'b1;
                  pc_en     = 1'b1;
                  pc_sel    = PCSEL_INC;
                  state_nxt = HOLD;
               end
            end else if (timeout_hit) begin
               drop_nxt  = 1'b0;
               state_nxt = IDLE;
            end else if (redirect_valid) begin
               drop_nxt = 1'b1;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               flush     = 1'b1;
               state_nxt = FETCH;
            end else if (ir_ready) begin
               state_nxt = run ? FETCH : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   fetch_ir_reg #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_ir (
      .clk      (clk),
      .rst      (rst),
      .capture  (capture),
      .flush    (flush),
      .data     (mem_rdata),
      .pc       (pc_cur),
      .ir_ready (ir_ready),
      .ir_valid (ir_valid),
      .ir_data  (ir_data),
      .ir_pc    (ir_pc)
   );

endmodule
